// File: rtl/fft16_sequencer.sv
// fft16_sequencer: loads 16 real samples in bit-reversed order, sequences the
// 4x8 in-place radix-2 DIT butterflies through an external combinational
// butterfly unit, then streams the 16 bins out in natural order.
module fft16_sequencer #(
   parameter int SAMPLE_W = 18,
   parameter int DATA_W   = 24
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [SAMPLE_W-1:0]   in_sample,
   output logic [2*DATA_W-1:0]   bf_a_t,
   output logic [2*DATA_W-1:0]   bf_b_t,
   output logic [2*DATA_W-1:0]   bf_w,
   input  logic [2*DATA_W-1:0]   bf_a_f,
   input  logic [2*DATA_W-1:0]   bf_b_f,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [2*DATA_W-1:0]   out_data,
   output logic [3:0]            out_index,
   output logic                  busy
);

   typedef enum logic [1:0] {LOAD, COMPUTE, UNLOAD} state_t;

   state_t              state, state_nxt;
   logic [3:0]          smp_cnt;     // next sample number in LOAD
   logic [1:0]          stage;       // DIT stage s
   logic [2:0]          bfly;        // butterfly j within the stage
   logic [3:0]          bin;         // bin being offered in UNLOAD
   logic [3:0]          top, bot;
   logic [2:0]          tw_k;
   logic                accept;
   logic [2*DATA_W-1:0] rf [16];

   function automatic logic [3:0] bitrev4(input logic [3:0] n);
      return {n[0], n[1], n[2], n[3]};
   endfunction

   // W^k = cos(2*pi*k/16) - j*sin(2*pi*k/16), Q1.23, {re, im}; +1.0 saturated.
   function automatic logic [47:0] twiddle(input logic [2:0] k);
      case (k)
         3'd0:    return 48'h7FFFFF_000000;
         3'd1:    return 48'h7641AF_CF043A;
         3'd2:    return 48'h5A827A_A57D86;
         3'd3:    return 48'h30FBC6_89BE51;
         3'd4:    return 48'h000000_800001;
         3'd5:    return 48'hCF043A_89BE51;
         3'd6:    return 48'hA57D86_A57D86;
         default: return 48'h89BE51_CF043A;
      endcase
   endfunction

   // Gated by rst_n so no sample is taken during a reset cycle.
   assign accept = in_valid && rst_n && (state == LOAD);

   // Butterfly pair and twiddle index: top = (j>>s)*2h + (j&(h-1)), k = (j&(h-1))<<(3-s).
   always_comb begin
      top  = 4'd0;
      tw_k = 3'd0;
      case (stage)
         2'd0: begin top = {bfly, 1'b0};                 tw_k = 3'd0;              end
         2'd1: begin top = {bfly[2:1], 1'b0, bfly[0]};   tw_k = {bfly[0], 2'b00};  end
         2'd2: begin top = {bfly[2], 1'b0, bfly[1:0]};   tw_k = {bfly[1:0], 1'b0}; end
         default: begin top = {1'b0, bfly};              tw_k = bfly;              end
      endcase
      bot = top | (4'd1 << stage);
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= LOAD;
      else        state <= state_nxt;
   end

   // Next state and all block outputs; everything idles at zero outside its phase.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      bf_a_t    = '0;
      bf_b_t    = '0;
      bf_w      = '0;
      out_data  = '0;
      out_index = 4'd0;
      case (state)
         LOAD: begin
            in_ready = rst_n;
            if (accept && smp_cnt == 4'd15) state_nxt = COMPUTE;
         end
         COMPUTE: begin
            busy   = 1'b1;
            bf_a_t = rf[top];
            bf_b_t = rf[bot];
            bf_w   = twiddle(tw_k);
            if (stage == 2'd3 && bfly == 3'd7) state_nxt = UNLOAD;
         end
         UNLOAD: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            out_data  = rf[bin];
            out_index = bin;
            if (out_ready && bin == 4'd15) state_nxt = LOAD;
         end
         default: state_nxt = LOAD;
      endcase
   end

   // Sequence counters; each wraps to zero at the end of its phase.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         smp_cnt <= 4'd0;
         stage   <= 2'd0;
         bfly    <= 3'd0;
         bin     <= 4'd0;
      end else begin
         if (accept)                          smp_cnt       <= smp_cnt + 4'd1;
         if (state == COMPUTE)                {stage, bfly} <= {stage, bfly} + 5'd1;
         if (state == UNLOAD && out_ready)    bin           <= bin + 4'd1;
      end
   end

   // Register file: bit-reversed sample load, then in-place butterfly writeback.
   always_ff @(posedge clk) begin
      if (accept) begin
         rf[bitrev4(smp_cnt)] <= {{(DATA_W-SAMPLE_W){in_sample[SAMPLE_W-1]}}, in_sample,
                                  {DATA_W{1'b0}}};
      end else if (state == COMPUTE) begin
         rf[top] <= bf_a_f;
         rf[bot] <= bf_b_f;
      end
   end

endmodule

// File: tb/tb_fft16_sequencer.sv
// Bench for fft16_sequencer: models the butterfly unit, checks bins against a
// floating-point DFT reference held in a scoreboard queue.
module tb_fft16_sequencer;

   logic        clk = 1'b0;
   logic        rst_n, in_valid, in_ready, out_valid, out_ready, busy;
   logic [17:0] in_sample;
   logic [47:0] bf_a_t, bf_b_t, bf_w, bf_a_f, bf_b_f, out_data;
   logic [3:0]  out_index;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int acc_cyc = 0;

   typedef struct { int idx; real re; real im; real tol; } exp_t;
   exp_t sb[$];

   fft16_sequencer dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_sample(in_sample), .bf_a_t(bf_a_t), .bf_b_t(bf_b_t), .bf_w(bf_w),
      .bf_a_f(bf_a_f), .bf_b_f(bf_b_f), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_index(out_index), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Butterfly unit: A +/- W*B, product rounded to nearest at Q1.23.
   function automatic logic [47:0] bfly(input logic [47:0] a, b, w, input bit is_top);
      longint ar, ai, br, bi, wr, wi, tr, ti, rr, ri;
      ar = longint'($signed(a[47:24])); ai = longint'($signed(a[23:0]));
      br = longint'($signed(b[47:24])); bi = longint'($signed(b[23:0]));
      wr = longint'($signed(w[47:24])); wi = longint'($signed(w[23:0]));
      tr = (wr * br - wi * bi + 64'sd4194304) >>> 23;
      ti = (wr * bi + wi * br + 64'sd4194304) >>> 23;
      rr = is_top ? ar + tr : ar - tr;
      ri = is_top ? ai + ti : ai - ti;
      return {rr[23:0], ri[23:0]};
   endfunction

   assign bf_a_f = bfly(bf_a_t, bf_b_t, bf_w, 1'b1);
   assign bf_b_f = bfly(bf_a_t, bf_b_t, bf_w, 1'b0);

   task automatic chk_eq(input string tag, input longint obs, input longint exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_near(input string tag, input longint obs, input real exp, input real tol);
      real d;
      bit  ok;
      d  = real'(obs) - exp;
      ok = (d <= tol) && (d >= -tol);
      checks++;
      assert (ok === 1'b1) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0.1f+-%0.1f", tag, obs, exp, tol);
      end
   endtask

   // Reference DFT of the frame, queued in natural bin order.
   task automatic push_frame(input int x[16], input real tol);
      exp_t e;
      real  a;
      for (int k = 0; k < 16; k++) begin
         e.idx = k; e.re = 0.0; e.im = 0.0; e.tol = tol;
         for (int n = 0; n < 16; n++) begin
            a    = 2.0 * 3.14159265358979 * real'(k * n) / 16.0;
            e.re = e.re + real'(x[n]) * $cos(a);
            e.im = e.im - real'(x[n]) * $sin(a);
         end
         sb.push_back(e);
      end
   endtask

   task automatic send_sample(input int v, input bit gaps);
      int t = 0;
      while (gaps && $urandom_range(0, 2) == 0) begin
         in_valid  = 1'b0;
         in_sample = 18'($urandom);
         @(posedge clk); #1;
      end
      in_valid  = 1'b1;
      in_sample = 18'(v);
      while (!in_ready && t < 200) begin @(posedge clk); #1; t++; end
      chk_eq("in_ready_timeout", longint'(t < 200), 1);
      acc_cyc = cyc;
      @(posedge clk); #1;
      in_valid  = 1'b0;
      in_sample = 18'($urandom);
   endtask

   task automatic send_frame(input int x[16], input bit gaps);
      for (int n = 0; n < 16; n++) send_sample(x[n], gaps);
   endtask

   // Walks the 32 compute cycles starting just after the 16th accept edge.
   task automatic wait_compute(input bit rom);
      for (int c = 0; c < 32; c++) begin
         chk_eq("in_ready_compute", in_ready, 0);
         chk_eq("busy_compute", busy, 1);
         chk_eq("out_valid_compute", out_valid, 0);
         if (rom) begin
            if (c == 0)  chk_eq("twiddle_k0", bf_w, 48'h7FFFFF_000000);
            if (c == 25) chk_eq("twiddle_k1", bf_w, 48'h7641AF_CF043A);
            if (c == 26) chk_eq("twiddle_k2", bf_w, 48'h5A827A_A57D86);
            if (c == 28) chk_eq("twiddle_k4", bf_w, 48'h000000_800001);
         end
         @(posedge clk); #1;
      end
      chk_eq("out_valid_first", out_valid, 1);
      chk_eq("latency", cyc - acc_cyc, 33);
   endtask

   task automatic check_bin();
      exp_t e;
      chk_eq("sb_underflow", longint'(sb.size() == 0), 0);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk_eq("bin_index", out_index, e.idx);
         chk_near($sformatf("bin%0d_re", e.idx), longint'($signed(out_data[47:24])), e.re, e.tol);
         chk_near($sformatf("bin%0d_im", e.idx), longint'($signed(out_data[23:0])), e.im, e.tol);
      end
   endtask

   task automatic recv_frame(input bit hold);
      int          got = 0, t = 0, held = 0;
      logic [47:0] hd = '0;
      logic [3:0]  hi = '0;
      while (got < 16 && t < 200) begin
         if (out_valid) begin
            if (hold && out_index == 4'd3 && held < 5) begin
               out_ready = 1'b0;
               if (held == 0) begin
                  hd = out_data;
                  hi = out_index;
               end else begin
                  chk_eq("hold_data", out_data, hd);
                  chk_eq("hold_index", out_index, hi);
               end
               held++;
            end else begin
               out_ready = 1'b1;
               chk_eq("in_ready_unload", in_ready, 0);
               check_bin();
               got++;
            end
         end
         @(posedge clk); #1;
         t++;
      end
      out_ready = 1'b1;
      chk_eq("frame_complete", got, 16);
      if (hold) chk_eq("hold_cycles", held, 5);
      chk_eq("out_valid_after_last", out_valid, 0);
      chk_eq("in_ready_after_last", in_ready, 1);
      chk_eq("busy_after_last", busy, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int x[16];
      rst_n = 1'b0; in_valid = 1'b0; in_sample = '0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk_eq("rst_in_ready", in_ready, 0);
      chk_eq("rst_out_valid", out_valid, 0);
      chk_eq("rst_busy", busy, 0);
      chk_eq("rst_out_data", out_data, 0);
      chk_eq("rst_out_index", out_index, 0);
      chk_eq("rst_bf_a_t", bf_a_t, 0);
      chk_eq("rst_bf_w", bf_w, 0);
      rst_n = 1'b1;
      #1;
      chk_eq("load_in_ready", in_ready, 1);

      // Impulse
      x = '{default: 0}; x[0] = 1000;
      push_frame(x, 4.0); send_frame(x, 1'b0); wait_compute(1'b1); recv_frame(1'b0);

      // DC
      x = '{default: 1000};
      push_frame(x, 4.0); send_frame(x, 1'b0); wait_compute(1'b0); recv_frame(1'b0);

      // Alternating full scale
      for (int n = 0; n < 16; n++) x[n] = (n % 2 == 1) ? -131071 : 131071;
      push_frame(x, 8.0); send_frame(x, 1'b0); wait_compute(1'b0); recv_frame(1'b0);

      // Random data, gappy input, stalled output at bin 3
      for (int n = 0; n < 16; n++) x[n] = int'($urandom_range(0, 262142)) - 131071;
      push_frame(x, 8.0); send_frame(x, 1'b1); wait_compute(1'b0); recv_frame(1'b1);

      // Reset in COMPUTE cycle 10 discards the frame
      for (int n = 0; n < 16; n++) x[n] = int'($urandom_range(0, 2000)) - 1000;
      push_frame(x, 8.0); send_frame(x, 1'b0);
      repeat (10) begin @(posedge clk); #1; end
      chk_eq("pre_reset_busy", busy, 1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      #1;
      chk_eq("midrst_in_ready", in_ready, 1);
      chk_eq("midrst_busy", busy, 0);
      chk_eq("midrst_out_valid", out_valid, 0);
      chk_eq("midrst_bf_w", bf_w, 0);
      sb.delete();
      for (int n = 0; n < 16; n++) x[n] = int'($urandom_range(0, 2000)) - 1000;
      push_frame(x, 8.0); send_frame(x, 1'b0); wait_compute(1'b0); recv_frame(1'b0);

      // Back-to-back cosine at bin 2
      for (int n = 0; n < 16; n++) x[n] = int'(10000.0 * $cos(2.0 * 3.14159265358979 * real'(2 * n) / 16.0));
      for (int f = 0; f < 2; f++) begin
         push_frame(x, 8.0); send_frame(x, 1'b0); wait_compute(1'b0); recv_frame(1'b0);
      end

      chk_eq("sb_drained", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fft16_sequencer.md
Name: fft16_sequencer

Overview:
- Control and data-storage stage sitting directly upstream of the combinational radix-2 butterfly unit in the audio-visualizer FFT path.
- Accepts 16 real 18-bit signed audio samples over a valid/ready stream and stores them in bit-reversed order in a 16x48-bit complex register file.
- Runs 4 decimation-in-time stages of 8 butterflies, one per cycle: drives A_t/B_t/W to the butterfly unit and writes A_f/B_f back in place.
- Streams the 16 frequency bins out in natural order.

Parameters:
- SAMPLE_W, 18, input sample width (signed two's complement)
- DATA_W, 24, real/imag component width (SAMPLE_W + 6 growth bits)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous reset, active-low
- in_valid  in  1  sample valid
- in_ready  out  1  sequencer accepts sample
- in_sample  in  18  signed time-domain sample
- bf_a_t  out  48  butterfly top input, [47:24] real, [23:0] imag
- bf_b_t  out  48  butterfly bottom input, same format
- bf_w  out  48  twiddle, same format, Q1.23 per component
- bf_a_f  in  48  butterfly top result (combinational from bf_*)
- bf_b_f  in  48  butterfly bottom result
- out_valid  out  1  bin valid
- out_ready  in  1  downstream accepts bin
- out_data  out  48  frequency bin, [47:24] real, [23:0] imag
- out_index  out  4  bin number 0..15 of out_data
- busy  out  1  high in COMPUTE and UNLOAD

Behaviour:
- Reset (rst_n=0 at a clk edge): state=LOAD, sample counter=0, stage=0, butterfly index=0, bin counter=0; in_ready=0 during the reset cycle; out_valid=0, out_data=0, out_index=0, busy=0, bf_a_t/bf_b_t/bf_w=0. Register file contents are don't-care. Reset takes effect from any state, including mid-COMPUTE and mid-UNLOAD; the partial frame is discarded.
- States: LOAD -> COMPUTE -> UNLOAD -> LOAD.
- LOAD:
  - in_ready=1.
  - On in_valid&in_ready, sample n (n = counter 0..15) is written to address bitrev4(n), e.g. 1->8, 3->12.
  - Real part = sign-extended to 24 bits; imag part = 0.
  - The 16th accept moves the state to COMPUTE on the next cycle.
- COMPUTE:
  - 32 cycles; stage s=0..3, butterfly j=0..7, j fastest.
  - h = 2^s; top = (j>>s)*2h + (j & (h-1)); bot = top + h; twiddle index k = (j & (h-1)) << (3-s).
  - bf_a_t = reg[top] and bf_b_t = reg[bot] (combinational read); bf_w = ROM[k].
  - At the clock edge, reg[top] <= bf_a_f and reg[bot] <= bf_b_f.
  - in_ready=0. Move to UNLOAD after s=3, j=7.
  - Latency: last input accept to first out_valid = 33 cycles.
- Twiddle ROM:
  - W^k = cos(2πk/16) - j·sin(2πk/16), k=0..7.
  - Each component = round-to-nearest(value·2^23); +1.0 saturates to 0x7FFFFF, -1.0 encodes as 0x800001.
  - k=0: (0x7FFFFF, 0x000000); k=2: (0x5A827A, -0x5A827A); k=4: (0x000000, 0x800001); k=1: (0x7641AF, -0x30FBC6).
  - bf_* = 0 outside COMPUTE.
- UNLOAD:
  - out_valid=1; out_data = reg[bin]; out_index = bin.
  - Bin advances only on out_valid&out_ready. out_data and out_index are stable while out_ready=0.
  - After bin 15 transfers: out_valid=0 and state=LOAD the next cycle. The first new sample can be accepted one cycle after the last transfer.
- Arithmetic: no saturation or rounding in this block. The 6 growth bits cover full-scale 16-point growth: max |bin0| = 16·131071 = 2097136 < 2^23.

Test Plan:
- Impulse: samples {1000,0×15}, out_ready=1 -> 16 bins, each real 1000±4 and imag 0±4; out_index 0..15 in order; first out_valid exactly 33 cycles after the 16th accept.
- DC: all samples 1000 -> bin0 real 16000±4; all other bins |re|,|im| ≤ 4.
- Alternating: x[n] = (-1)^n·131071 -> bin8 real 2097136±8, others ≤ 8; no wraparound in the 24-bit field.
- Handshake: in_valid toggled randomly during LOAD, and out_ready held low 5 cycles at bin 3 -> samples are neither lost nor duplicated; out_data/out_index are held constant; bins match the bit-accurate model.
- Reset mid-COMPUTE: rst_n=0 for 1 cycle at COMPUTE cycle 10 -> next cycle state=LOAD, in_ready=1, busy=0, out_valid=0. A following full frame produces the correct bins.
- Back-to-back frames: two frames of a cosine at bin 2 (amplitude 10000) -> bins 2 and 14 are 80000±8 real in both frames; in_ready is low from the 16th accept until one cycle after the last bin transfer.
